mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs and performs the data-memory access over a req/ack bus. It holds the pipeline with `stall` while an access is outstanding, then aligns and sign-extends load data for MEM/WB. It also resolves branches from `Branch`/`zero`. It sits between the EX/MEM and MEM/WB pipeline registers; `stall` drives the `write` enables of the upstream pipe registers.

## Interface
- `XLEN`, 32, data/address width (only 32 is supported).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `zero_in`, `Branch_in` in 1: from EX/MEM.
- `ALU_in` in 32: byte address.
- `PC_in` in 32: branch target.
- `reg2_data_in` in 32: store data.
- `func3_in` in 3: access size/sign, or branch sense.
- `MemRead_in`, `MemWrite_in` in 1: access request.
- `mem_req` out 1: bus request, held until ack.
- `mem_we` out 1: write strobe.
- `mem_addr` out 32: word address; bits [1:0] = 0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-steered store data.
- `mem_ack` in 1: completes the access in the cycle it is seen with `mem_req`.
- `mem_rdata` in 32: read word, valid with `mem_ack`.
- `load_data` out 32: aligned and extended load result.
- `stall` out 1: freeze upstream pipeline.
- `access_fault` out 1: one-cycle pulse for a misaligned or illegal access.
- `pcsrc` out 1: take branch.
- `branch_target` out 32: equals `PC_in`.

## Operation
- Access = `MemRead_in | MemWrite_in`. If both are set, the write wins.
- FSM states are IDLE, REQ, and DONE.
  - IDLE → REQ when a legal access is present.
  - REQ → DONE on `mem_ack`.
  - DONE → IDLE unconditionally.
- `stall` = access present and state != DONE. It is combinational and is also asserted in IDLE during the detect cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be`, and `mem_wdata` are registered on the IDLE→REQ edge and held stable throughout REQ. All are 0 outside REQ.
- Store encodings by `func3`:
  - 000 SB: be = 0001 << a[1:0]; data byte replicated across all lanes.
  - 001 SH: be = 0011 << a[1:0]; half replicated.
  - 010 SW: be = 1111.
- Load encodings by `func3`:
  - 000 LB and 100 LBU: sign- or zero-extend the byte at a[1:0].
  - 001 LH and 101 LHU: sign- or zero-extend the half at a[1].
  - 010 LW: the full word.
- Loads drive be = 1111.
- `load_data` is captured from `mem_rdata` on ack. It holds until the next load completes and is 0 after reset.
- A fault is any of: half with a[0]=1, word with a[1:0]≠0, or load `func3` ∈ {011,110,111}, or store `func3` ≥ 011. On a fault: no bus request, state goes IDLE→DONE, `access_fault` pulses in the DONE cycle, and `load_data` ← 0.
- `pcsrc` = `Branch_in & (zero_in ^ func3_in[0])`. This covers BEQ (000) and BNE (001). It is combinational and independent of the FSM.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_be`, `access_fault`, and `stall` all 0; `mem_addr`, `mem_wdata`, and `load_data` all 0.
- Reset mid-access drops `mem_req` immediately (asynchronously).
- Minimum access cost is 2 stall cycles: detect (IDLE), then REQ with ack in the same cycle. `load_data` is valid in DONE, where `stall` = 0.
- Each wait state adds one stall cycle. There is no timeout.
- A fault costs 1 stall cycle.
- Back-to-back accesses: DONE always returns to IDLE, so a new access is detected the cycle after DONE.
- `mem_ack` without `mem_req` is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses fault as described in Operation.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned addresses are force-aligned (half clears a[0]; word clears a[1:0]) and the access proceeds.
  - `access_fault` fires only for illegal `func3`.

## Structure
- Package `mem_stage_pkg` holds:
  - the FSM state enum;
  - the `func3` constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the BEQ/BNE `func3` codes.
- Sub-module `lsu_align` (combinational) covers byte-enable generation, store lane steering, load extraction/extension, and fault detection.
- The FSM and registers live in `mem_stage_lsu`.

## Test plan
- SW, address 0x100, data 0xDEADBEEF, ack on the first REQ cycle → `mem_be`=1111, `mem_addr`=0x100, `mem_we`=1; `stall` high for exactly 2 cycles.
- LB at 0x203 with `mem_rdata`=0x80FF_0000 → `load_data`=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- LH at 0x102 with ack delayed 3 cycles → `stall` high 5 cycles, `mem_req` held for 4 cycles with stable address; `rdata`=0x8001_1234 gives `load_data`=0xFFFF_8001.
- SH at 0x101 with trap enabled → no `mem_req`, `access_fault` 1-cycle pulse, `stall` 1 cycle. With the macro undefined → `mem_be`=0011 at 0x100.
- Assert `reset` low during REQ → `mem_req` drops immediately. After release, the FSM is in IDLE and `load_data`=0.
- Branch=1, func3=001, zero=0, PC_in=0x40 → `pcsrc`=1, `branch_target`=0x40. With zero=1 → `pcsrc`=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
//   lsu_state_e : access FSM states (idle / bus request / completion)
//   F3_*        : func3 encodings for access size and sign, and for BEQ/BNE
//   f3_size     : access size field carried in func3[1:0]
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10
  } lsu_state_e;

  // Load/store size and sign encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Branch sense encodings; only bit 0 distinguishes them.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  function automatic logic [1:0] f3_size(input logic [2:0] func3);
    return func3[1:0];
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the LSU (master) and the memory (slave).
//   mem_req   : request, held until mem_ack
//   mem_we    : write strobe
//   mem_addr  : word-aligned address
//   mem_be    : byte enables
//   mem_wdata : lane-steered store data
//   mem_ack   : completes the access in the cycle it is seen with mem_req
//   mem_rdata : read word, valid with mem_ack
interface mem_stage_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helper for the memory-stage LSU.
//   addr_i/func3_i/is_store_i/store_data_i : current access request
//   word_addr_o  : word-aligned bus address
//   be_o/wdata_o : byte enables and lane-steered store data
//   offset_o     : effective byte offset (after any forced alignment)
//   fault_o      : illegal func3, or misalignment when trapping is enabled
//   ld_offset_i/ld_func3_i/rdata_i : captured load info and read word
//   load_o       : extracted and extended load value
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned accesses fault; without
// it they are force-aligned to their natural size.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  func3_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] word_addr_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  offset_o,
  output logic        fault_o,
  input  logic [1:0]  ld_offset_i,
  input  logic [2:0]  ld_func3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_o
);

  logic       illegal;
  logic [1:0] off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
`endif

  always_comb begin
    illegal = is_store_i ? (func3_i >= 3'b011)
                         : (func3_i == 3'b011 || func3_i == 3'b110 || func3_i == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((f3_size(func3_i) == 2'b01) && addr_i[0]) ||
                 ((f3_size(func3_i) == 2'b10) && (addr_i[1:0] != 2'b00));
    fault_o    = illegal | misaligned;
    off        = addr_i[1:0];
`else
    fault_o = illegal;
    // Clear the low address bits below the access size.
    case (f3_size(func3_i))
      2'b00:   off = addr_i[1:0];
      2'b01:   off = {addr_i[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = '0;
    if (is_store_i) begin
      case (f3_size(func3_i))
        2'b00: begin
          be_o    = 4'b0001 << off;
          wdata_o = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << off;
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = store_data_i;
        end
      endcase
    end
  end

  assign word_addr_o = {addr_i[31:2], 2'b00};
  assign offset_o    = off;

  always_comb begin
    ld_byte = rdata_i[{ld_offset_i, 3'b000} +: 8];
    ld_half = rdata_i[{ld_offset_i[1], 4'b0000} +: 16];
    case (ld_func3_i)
      F3_B:    load_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_o = {24'b0, ld_byte};
      F3_H:    load_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_o = {16'b0, ld_half};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit between the EX/MEM and MEM/WB registers.
//   clk, reset (async, active low)
//   zero_in/Branch_in/PC_in/func3_in : branch resolution -> pcsrc, branch_target
//   ALU_in/reg2_data_in/MemRead_in/MemWrite_in : access request from EX/MEM
//   bus          : req/ack data-memory bus (master side)
//   load_data    : aligned/extended load result, held until the next load
//   stall        : freezes upstream pipe registers while an access is pending
//   access_fault : one-cycle pulse for an illegal or misaligned access
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_align).
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            zero_in,
  input  logic            Branch_in,
  input  logic [XLEN-1:0] ALU_in,
  input  logic [XLEN-1:0] PC_in,
  input  logic [XLEN-1:0] reg2_data_in,
  input  logic [2:0]      func3_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  mem_stage_lsu_if.master bus,
  output logic [XLEN-1:0] load_data,
  output logic            stall,
  output logic            access_fault,
  output logic            pcsrc,
  output logic [XLEN-1:0] branch_target
);

  lsu_state_e  state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] load_data_q;
  logic        is_load_q;
  logic [1:0]  ld_off_q;
  logic [2:0]  ld_f3_q;

  logic        access;
  logic        is_store;
  logic [31:0] word_addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [1:0]  offset;
  logic        fault;
  logic [31:0] load_val;

  // Write wins when both request bits are set.
  assign access   = MemRead_in | MemWrite_in;
  assign is_store = MemWrite_in;

  lsu_align u_align (
    .addr_i       (ALU_in),
    .func3_i      (func3_in),
    .is_store_i   (is_store),
    .store_data_i (reg2_data_in),
    .word_addr_o  (word_addr),
    .be_o         (be),
    .wdata_o      (wdata),
    .offset_o     (offset),
    .fault_o      (fault),
    .ld_offset_i  (ld_off_q),
    .ld_func3_i   (ld_f3_q),
    .rdata_i      (bus.mem_rdata),
    .load_o       (load_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      is_load_q   <= 1'b0;
      ld_off_q    <= '0;
      ld_f3_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access) begin
            if (fault) begin
              // Faulting access never reaches the bus.
              state_q     <= StDone;
              fault_q     <= 1'b1;
              load_data_q <= '0;
            end else begin
              state_q   <= StReq;
              req_q     <= 1'b1;
              we_q      <= is_store;
              addr_q    <= word_addr;
              be_q      <= be;
              wdata_q   <= wdata;
              is_load_q <= ~is_store;
              ld_off_q  <= offset;
              ld_f3_q   <= func3_in;
            end
          end
        end
        StReq: begin
          if (bus.mem_ack) begin
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            if (is_load_q) begin
              load_data_q <= load_val;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          fault_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

  // Also high in the idle detect cycle so the pipe never slips past an access.
  assign stall         = access && (state_q != StDone);
  assign access_fault  = fault_q;
  assign load_data     = load_data_q;

  // BEQ takes on zero, BNE on non-zero.
  assign pcsrc         = Branch_in & (zero_in ^ func3_in[0]);
  assign branch_target = PC_in;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic        fault;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        is_load;
    logic [31:0] load;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        zero_in, Branch_in, MemRead_in, MemWrite_in;
  logic [31:0] ALU_in, PC_in, reg2_data_in;
  logic [2:0]  func3_in;
  logic [31:0] load_data, branch_target;
  logic        stall, access_fault, pcsrc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_load = '0;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .zero_in      (zero_in),
    .Branch_in    (Branch_in),
    .ALU_in       (ALU_in),
    .PC_in        (PC_in),
    .reg2_data_in (reg2_data_in),
    .func3_in     (func3_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .bus          (bus),
    .load_data    (load_data),
    .stall        (stall),
    .access_fault (access_fault),
    .pcsrc        (pcsrc),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference behaviour from the access rules, using byte arithmetic.
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] rdat);
    exp_t        m;
    int          size;
    int          off;
    bit          illegal;
    bit          misal;
    logic [63:0] mask;
    logic [63:0] w;
    logic [63:0] v;
    m = '0;
    case (f3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      default: size = 4;
    endcase
    if (wr) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    off   = int'(a % 4);
    misal = (off % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    m.fault = illegal || misal;
`else
    m.fault = illegal;
    off     = off - (off % size);
`endif
    m.addr    = a - (a % 4);
    m.is_load = rd && !wr;
    mask      = (64'd1 << (8 * size)) - 64'd1;
    if (wr) begin
      m.be = 4'(((1 << size) - 1) << off);
      w    = '0;
      for (int i = 0; i < 4 / size; i++) w = w | (({32'b0, d} & mask) << (8 * size * i));
      m.wdata = w[31:0];
    end else begin
      m.be    = 4'hF;
      m.wdata = '0;
      v = ({32'b0, rdat} >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      m.load = v[31:0];
    end
    return m;
  endfunction

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdat, input int waits,
                           input logic br, input logic zr);
    exp_t m;
    int   stall_n = 0;
    int   req_n = 0;
    int   cyc = 0;
    bit   done = 0;
    m = model(rd, wr, f3, a, d, rdat);
    @(negedge clk);
    MemRead_in   = rd;
    MemWrite_in  = wr;
    func3_in     = f3;
    ALU_in       = a;
    reg2_data_in = d;
    Branch_in    = br;
    zero_in      = zr;
    PC_in        = $urandom;
    while (!done && cyc < 40) begin
      #1;
      chk("pcsrc", {31'b0, pcsrc}, {31'b0, br && (f3[0] ? !zr : zr)});
      if (bus.mem_req) begin
        req_n++;
        chk("mem_addr", bus.mem_addr, m.addr);
        chk("mem_be", {28'b0, bus.mem_be}, {28'b0, m.be});
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, wr});
        chk("mem_wdata", bus.mem_wdata, m.wdata);
        if (req_n > waits) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdat;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        chk("idle_bus", {27'b0, bus.mem_we, bus.mem_be} | bus.mem_addr | bus.mem_wdata, 32'h0);
        // Stray acks outside a request must be ignored.
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      if (stall) begin
        stall_n++;
        chk("fault_low", {31'b0, access_fault}, 32'h0);
      end else begin
        done = 1;
        if (m.fault) exp_load = '0;
        else if (m.is_load) exp_load = m.load;
        chk("access_fault", {31'b0, access_fault}, {31'b0, m.fault});
        chk("load_data", load_data, exp_load);
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        bus.mem_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("completed", {31'b0, done}, 32'h1);
    chk("stall_cycles", stall_n, m.fault ? 32'd1 : 32'(waits + 2));
    chk("req_cycles", req_n, m.fault ? 32'd0 : 32'(waits + 1));
  endtask

  initial begin
    reset         = 1'b0;
    zero_in       = 1'b0;
    Branch_in     = 1'b0;
    MemRead_in    = 1'b0;
    MemWrite_in   = 1'b0;
    ALU_in        = '0;
    PC_in         = '0;
    reg2_data_in  = '0;
    func3_in      = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    #1;
    chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
    chk("rst_bus", {27'b0, bus.mem_we, bus.mem_be} | bus.mem_addr | bus.mem_wdata, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_fault", {31'b0, access_fault}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    do_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, F3_B, 32'h203, 32'h0, 32'h80FF0000, 0, 1'b0, 1'b0);
    chk("lb_value", load_data, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, F3_BU, 32'h203, 32'h0, 32'h80FF0000, 1, 1'b0, 1'b0);
    chk("lbu_value", load_data, 32'h00000080);
    do_access(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h80011234, 3, 1'b0, 1'b0);
    chk("lh_value", load_data, 32'hFFFF8001);
    do_access(1'b0, 1'b1, F3_H, 32'h101, 32'hA5A51234, 32'h0, 0, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 3'b110, 32'h40, 32'h0, 32'h12345678, 0, 1'b0, 1'b0);
    do_access(1'b1, 1'b1, F3_B, 32'h52, 32'h000000C3, 32'h0, 2, 1'b0, 1'b0);

    // Branch resolution with no access
    @(negedge clk);
    Branch_in = 1'b1;
    func3_in  = F3_BNE;
    zero_in   = 1'b0;
    PC_in     = 32'h40;
    #1;
    chk("bne_taken", {31'b0, pcsrc}, 32'h1);
    chk("branch_target", branch_target, 32'h40);
    zero_in = 1'b1;
    #1;
    chk("bne_not_taken", {31'b0, pcsrc}, 32'h0);
    func3_in = F3_BEQ;
    #1;
    chk("beq_taken", {31'b0, pcsrc}, 32'h1);
    Branch_in = 1'b0;
    #1;
    chk("no_branch", {31'b0, pcsrc}, 32'h0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [1:0] k;
      k = 2'($urandom_range(1, 3));
      do_access(k[0], k[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a request
    do_access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'hCAFEF00D, 0, 1'b0, 1'b0);
    @(negedge clk);
    MemRead_in = 1'b1;
    func3_in   = F3_W;
    ALU_in     = 32'h304;
    @(negedge clk);
    #1;
    chk("req_before_reset", {31'b0, bus.mem_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("req_dropped", {31'b0, bus.mem_req}, 32'h0);
    MemRead_in = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    exp_load = '0;
    #1;
    chk("state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("load_after_reset", load_data, 32'h0);
    chk("stall_after_reset", {31'b0, stall}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
